// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Inter-stage pipeline register (EX/MEM, MEM/WB) with a valid/ready handshake.
// It carries a data payload and a control field. The control field is cleared
// on flush, and out_ctrl reads zero whenever no entry is presented, so a bubble
// never drives a register write or a memory strobe. The stage also keeps a
// saturating count of back-pressure cycles.
//
// Build option:
//   SKID_BUFFER_EN  defined   -> two-entry skid buffer with a registered
//                                in_ready. Gives full throughput under
//                                single-cycle stalls with no combinational
//                                ready path.
//                   undefined -> single entry, in_ready = !out_valid || out_ready.
//
// Parameters:
//   DATA_W  payload width (held, cleared only by reset)
//   CTRL_W  control width (cleared by reset and flush)
//   CNT_W   stall counter width
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   flush        synchronous flush; drops every held entry at this edge
//   in_valid     upstream entry present
//   in_ready     stage accepts this cycle
//   in_data      upstream payload
//   in_ctrl      upstream control
//   out_valid    entry presented downstream
//   out_ready    downstream accepts
//   out_data     held payload
//   out_ctrl     held control, forced to 0 when out_valid is 0
//   stall_count  saturating count of cycles with out_valid && !out_ready
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_count
);

  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [CNT_W-1:0]  stall_q;

`ifdef SKID_BUFFER_EN
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              in_ready_q;
  logic              main_load, main_from_skid, skid_load;
  logic [DATA_W-1:0] skid_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;

  // NOTE: sequential state uses non-blocking (<=) assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      // Ready is derived from the next state, so it is a clean flop output.
      in_ready_q <= (state_d != ST_SKID);
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_valid) begin
            main_load = 1'b1;
            state_d   = ST_FULL;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            if (in_valid) main_load = 1'b1;
            else          state_d   = ST_EMPTY;
          end else if (in_valid) begin
            // Downstream stalled while upstream still believed we were ready.
            skid_load = 1'b1;
            state_d   = ST_SKID;
          end
        end
        ST_SKID: begin
          if (out_ready) begin
            main_from_skid = 1'b1;
            state_d        = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // NOTE: the payload registers are reset even though they are pure storage,
  // because out_data must read zero while reset is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else if (flush) begin
      // Payload is deliberately left alone; only control is scrubbed.
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      if (main_load) begin
        main_data_q <= in_data;
        main_ctrl_q <= in_ctrl;
      end else if (main_from_skid) begin
        main_data_q <= skid_data_q;
        main_ctrl_q <= skid_ctrl_q;
      end
      if (skid_load) begin
        skid_data_q <= in_data;
        skid_ctrl_q <= in_ctrl;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
`else
  logic valid_q;
  logic load;

  // Combinational ready: a full stage can still accept when downstream drains.
  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      main_data_q <= '0;
      main_ctrl_q <= '0;
    end else if (flush) begin
      valid_q     <= 1'b0;
      main_ctrl_q <= '0;
    end else if (load) begin
      valid_q     <= 1'b1;
      main_data_q <= in_data;
      main_ctrl_q <= in_ctrl;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
`endif

  // Back-pressure counter; flush does not disturb it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_data    = main_data_q;
  assign out_ctrl    = out_valid ? main_ctrl_q : '0;
  assign stall_count = stall_q;

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the RISC-V core: the successor to the fixed-field stage latches between EX, MEM and WB. It carries a data payload and a separately clearable control field under a valid/ready handshake, supports synchronous flush (bubble insertion) and downstream back-pressure, and counts back-pressure cycles. An optional two-entry skid buffer registers the upstream ready so the stall path from data memory does not ripple combinationally through the pipeline.

## Interface
Parameters:
- DATA_W, 64: payload width (e.g. ALU result + store data); held, never cleared except on reset.
- CTRL_W, 12: control width (reg write enable, mem read/write, funct3, rd address, etc.); cleared on reset and flush.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state immediately while low.
- flush  in  1  synchronous flush; drops all held entries this edge.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts (i.e. not busywait).
- out_data  out  DATA_W  held payload.
- out_ctrl  out  CTRL_W  held control; forced 0 when out_valid is 0.
- stall_count  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Transfer in: in_valid && in_ready at an edge. Transfer out: out_valid && out_ready at an edge.
- out_ctrl is 0 whenever out_valid is 0, so a bubble never asserts reg write or memory strobes.
- flush (highest priority after reset): next edge, all entries invalid, out_ctrl = 0, any simultaneous input transfer discarded, state EMPTY. out_data keeps its previous value. stall_count unaffected.
- With skid buffer, states:
  - EMPTY: in_ready=1. in_valid -> load main, FULL.
  - FULL: in_ready=1. out_ready && in_valid -> main <= input, stay FULL. out_ready && !in_valid -> EMPTY. !out_ready && in_valid -> skid <= input, SKID. !out_ready && !in_valid -> hold.
  - SKID: in_ready=0. out_ready -> main <= skid, FULL. Otherwise hold both.
  - in_ready is a register output: 1 in EMPTY/FULL, 0 in SKID.
- Without skid buffer: single entry; in_ready = !out_valid || out_ready (combinational). Load on input transfer; clear valid on output transfer without simultaneous input transfer.
- Ordering strictly FIFO; no entry duplicated or lost except by flush.
- stall_count increments by 1 per back-pressure cycle and saturates at all-ones.

## Timing
- Reset values: out_valid=0, out_ctrl=0, out_data=0, stall_count=0, in_ready=1, state EMPTY, skid entry invalid and zero.
- Latency: input accepted at edge N appears on out_* after edge N (visible in cycle N+1).
- Throughput: one transfer per cycle when out_ready stays high.
- Reset asserted mid-operation: all entries lost immediately (asynchronous); first acceptance possible on the first edge after release.
- flush and out_ready high together: the presented entry counts as consumed by downstream; the stage is still empty after the edge.

## Configuration
- SKID_BUFFER_EN defined: two-entry skid buffer, registered in_ready, state machine as above; full throughput under single-cycle stalls with no combinational in_ready path.
- SKID_BUFFER_EN undefined: single-entry register with combinational in_ready; no skid storage or SKID state is synthesised.

## Test plan
- Reset low during traffic, data 0xDEADBEEF held -> out_valid=0, out_ctrl=0, out_data=0, stall_count=0 immediately; in_ready=1 after release.
- Stream 8 entries with out_ready=1 -> each appears one cycle after acceptance, in order, zero stall cycles.
- With SKID_BUFFER_EN: accept A, drop out_ready for 3 cycles while presenting B, C -> B stored in skid, in_ready=0 from next cycle, C held upstream; after release out sequence A, B, C; stall_count=3.
- Without SKID_BUFFER_EN: same stimulus -> in_ready falls in the same cycle out_ready falls; sequence A, B, C; stall_count=3.
- Flush in SKID state with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; skid and input entries never appear.
- CNT_W=4, hold out_ready=0 with out_valid=1 for 20 cycles -> stall_count stops at 15.
